// File: rtl/instr_rom_arbiter.sv
// Two-requester (IF / load-store) arbiter for the instruction ROM read port with registered responses.
// Optional LS starvation guard is enabled by defining ROM_ARB_STARVE_GUARD_EN.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef TEXT_HI
`define TEXT_HI 64'h0000_0000_0000_0FFF
`endif

module instr_rom_arbiter #(
  parameter int unsigned   XLEN    = `XLEN_64b,
  parameter logic [63:0]   TEXT_HI = `TEXT_HI,
`ifdef ROM_ARB_STARVE_GUARD_EN
  parameter int unsigned   STARVE_LIMIT = 4,
`endif
  localparam int unsigned  AW      = 1 << (XLEN + 4)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_adr,
  output logic          o_if_gnt,
  output logic          o_if_valid,
  output logic [31:0]   o_if_instr,
  output logic          o_if_fault,
  input  logic          i_ls_req,
  input  logic [AW-1:0] i_ls_adr,
  output logic          o_ls_gnt,
  output logic          o_ls_valid,
  output logic [31:0]   o_ls_data,
  output logic          o_ls_fault,
  output logic [AW-1:0] o_rom_adr,
  input  logic [31:0]   i_rom_instr
);

  localparam logic [AW-1:0] LAST_WORD = AW'(TEXT_HI - 64'd3);

  typedef enum logic [1:0] {ST_IDLE, ST_IF, ST_LS} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_if_win;
  logic          w_ls_win;
  logic          w_if_flt;
  logic          w_ls_flt;
  logic          w_force_ls;
  logic [AW-1:0] w_rom_adr;
  logic [31:0]   r_if_instr;
  logic          r_if_fault;
  logic [31:0]   r_ls_data;
  logic          r_ls_fault;

  function automatic logic adr_fault(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || (a > LAST_WORD);
  endfunction

  assign w_if_flt = adr_fault(i_if_adr);
  assign w_ls_flt = adr_fault(i_ls_adr);

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = (STARVE_LIMIT < 7) ? 3 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_starve;

  assign w_force_ls = (r_starve == CW'(STARVE_LIMIT));

  // Counts consecutive LS denials; saturates at the limit until LS is served.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve <= '0;
    end else if (w_ls_win) begin
      r_starve <= '0;
    end else if (i_ls_req && !w_force_ls) begin
      r_starve <= r_starve + CW'(1);
    end
  end
`else
  assign w_force_ls = 1'b0;
`endif

  // Arbitration and next pending-response owner.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_if_win    = 1'b0;
    w_ls_win    = 1'b0;
    w_rom_adr   = '0;
    if (!i_rst) begin
      if (i_ls_req && (w_force_ls || !(i_if_req && !i_flush))) begin
        w_ls_win = 1'b1;
      end else if (i_if_req && !i_flush) begin
        w_if_win = 1'b1;
      end
    end
    if (w_if_win) begin
      w_state_nxt = ST_IF;
      w_rom_adr   = w_if_flt ? '0 : i_if_adr;
    end else if (w_ls_win) begin
      w_state_nxt = ST_LS;
      w_rom_adr   = w_ls_flt ? '0 : i_ls_adr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_if_instr <= '0;
      r_if_fault <= 1'b0;
      r_ls_data  <= '0;
      r_ls_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_if_win) begin
        r_if_instr <= w_if_flt ? '0 : i_rom_instr;
        r_if_fault <= w_if_flt;
      end
      if (w_ls_win) begin
        r_ls_data  <= w_ls_flt ? '0 : i_rom_instr;
        r_ls_fault <= w_ls_flt;
      end
    end
  end

  assign o_if_gnt   = w_if_win;
  assign o_ls_gnt   = w_ls_win;
  assign o_rom_adr  = w_rom_adr;
  // A redirect in the response cycle drops the stale IF word.
  assign o_if_valid = (r_state == ST_IF) && !i_flush;
  assign o_ls_valid = (r_state == ST_LS);
  assign o_if_instr = r_if_instr;
  assign o_if_fault = r_if_fault;
  assign o_ls_data  = r_ls_data;
  assign o_ls_fault = r_ls_fault;

endmodule

// File: tb/tb_instr_rom_arbiter.sv
// Directed scoreboard bench for instr_rom_arbiter (32-bit addresses, TEXT_HI = 0x3FF).
module tb_instr_rom_arbiter;

  localparam logic [31:0] TB_TEXT_HI = 32'h0000_03FF;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req, ls_req;
  logic [31:0] if_adr, ls_adr;
  logic        if_gnt, if_valid, if_fault;
  logic        ls_gnt, ls_valid, ls_fault;
  logic [31:0] if_instr, ls_data, rom_adr, rom_instr;

  int n_chk  = 0;
  int n_fail = 0;
  resp_t if_q[$];
  resp_t ls_q[$];

  instr_rom_arbiter #(.XLEN(1), .TEXT_HI(64'(TB_TEXT_HI))) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_if_req(if_req), .i_if_adr(if_adr), .o_if_gnt(if_gnt), .o_if_valid(if_valid),
    .o_if_instr(if_instr), .o_if_fault(if_fault),
    .i_ls_req(ls_req), .i_ls_adr(ls_adr), .o_ls_gnt(ls_gnt), .o_ls_valid(ls_valid),
    .o_ls_data(ls_data), .o_ls_fault(ls_fault),
    .o_rom_adr(rom_adr), .i_rom_instr(rom_instr)
  );

  always #5 clk = ~clk;

  // ROM contents: word index tagged with a recognisable constant.
  assign rom_instr = 32'hC0DE_0000 | (rom_adr >> 2);

  function automatic logic m_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > TB_TEXT_HI - 32'd3);
  endfunction

  function automatic resp_t m_resp(input logic [31:0] a);
    resp_t r;
    r.fault = m_fault(a);
    r.data  = r.fault ? 32'h0 : (32'hC0DE_0000 | (a >> 2));
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: entered at posedge+1, drives inputs, checks, advances to next posedge+1.
  task automatic cycle(input string tag, input logic ifr, input logic [31:0] ifa,
                       input logic lsr, input logic [31:0] lsa, input logic fl,
                       input logic exp_ifg, input logic exp_lsg);
    logic        exp_ifv;
    logic        exp_lsv;
    logic [31:0] exp_adr;
    resp_t       e;
    if_req = ifr; if_adr = ifa; ls_req = lsr; ls_adr = lsa; flush = fl;
    #2;
    exp_adr = 32'h0;
    if (exp_ifg)      exp_adr = m_fault(ifa) ? 32'h0 : ifa;
    else if (exp_lsg) exp_adr = m_fault(lsa) ? 32'h0 : lsa;
    check({tag, ".if_gnt"},  64'(if_gnt),  64'(exp_ifg));
    check({tag, ".ls_gnt"},  64'(ls_gnt),  64'(exp_lsg));
    check({tag, ".rom_adr"}, 64'(rom_adr), 64'(exp_adr));
    exp_ifv = (if_q.size() > 0) && !fl;
    exp_lsv = (ls_q.size() > 0);
    check({tag, ".if_valid"}, 64'(if_valid), 64'(exp_ifv));
    check({tag, ".ls_valid"}, 64'(ls_valid), 64'(exp_lsv));
    if (if_q.size() > 0) begin
      e = if_q.pop_front();
      if (exp_ifv) begin
        check({tag, ".if_instr"}, 64'(if_instr), 64'(e.data));
        check({tag, ".if_fault"}, 64'(if_fault), 64'(e.fault));
      end
    end
    if (ls_q.size() > 0) begin
      e = ls_q.pop_front();
      check({tag, ".ls_data"},  64'(ls_data),  64'(e.data));
      check({tag, ".ls_fault"}, 64'(ls_fault), 64'(e.fault));
    end
    if (exp_ifg) if_q.push_back(m_resp(ifa));
    if (exp_lsg) ls_q.push_back(m_resp(lsa));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ls_done;
    logic exp_ls;
    // Reset: requests present but nothing granted, all outputs zero.
    rst = 1'b1; flush = 1'b0;
    if_req = 1'b1; if_adr = 32'h4; ls_req = 1'b1; ls_adr = 32'h8;
    #2;
    check("rst.if_gnt",  64'(if_gnt),  64'd0);
    check("rst.ls_gnt",  64'(ls_gnt),  64'd0);
    check("rst.rom_adr", 64'(rom_adr), 64'd0);
    check("rst.valids",  64'({if_valid, ls_valid}), 64'd0);
    check("rst.data",    64'({if_instr, ls_data}),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-response: grant, then async reset before the response edge completes its cycle.
    cycle("rstmid", 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; if_req = 1'b0;
    #1;
    check("rstmid.if_valid", 64'(if_valid), 64'd0);
    check("rstmid.if_instr", 64'(if_instr), 64'd0);
    check("rstmid.if_fault", 64'(if_fault), 64'd0);
    if_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle("rstrel", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // IF only, back-to-back.
    cycle("if0", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("if1", 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("if2", 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("if3", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Contention: IF priority; the guard forces an LS grant in the fifth cycle.
    ls_done = 1'b0;
    for (int k = 1; k <= 6; k++) begin
`ifdef ROM_ARB_STARVE_GUARD_EN
      exp_ls = (k == 5);
`else
      exp_ls = 1'b0;
`endif
      cycle($sformatf("cont%0d", k), 1'b1, 32'h10, !ls_done, 32'h20, 1'b0, !exp_ls, exp_ls);
      if (exp_ls) ls_done = 1'b1;
    end
    cycle("cont_ls", 1'b0, 32'h0, !ls_done, 32'h20, 1'b0, 1'b0, !ls_done);
    cycle("cont_dr", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Faults and the top-of-ROM boundary.
    cycle("flt_ls",  1'b0, 32'h0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
    cycle("flt_if",  1'b1, TB_TEXT_HI - 32'd1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("last_ok", 1'b1, TB_TEXT_HI - 32'd3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("past_hi", 1'b1, TB_TEXT_HI + 32'd1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("flt_dr",  1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush: IF response dropped, LS granted in the flush cycle.
    cycle("fl_n0", 1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0);
    cycle("fl_n1", 1'b1, 32'h44, 1'b1, 32'h30, 1'b1, 1'b0, 1'b1);
    cycle("fl_n2", 1'b1, 32'h44, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0);
    cycle("fl_dr", 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 1'b0);

    // Same address from both requesters: served on consecutive grants.
    cycle("same0", 1'b1, 32'h50, 1'b1, 32'h50, 1'b0, 1'b1, 1'b0);
    cycle("same1", 1'b0, 32'h0,  1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
    cycle("same2", 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 1'b0);

    // Idle.
    for (int k = 0; k < 10; k++) begin
      cycle($sformatf("idle%0d", k), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
